// File: rtl/dp_executor_if.sv
// Bundle of the sequencer handshake, VGA pixel port and NN weight memory port.
// Latency: n/a (wires only).
// Backpressure: none; the sequencer paces itself on finished.
//
// Ports (signal groups):
//   start/instruction  : sequencer -> executor request
//   finished/result    : executor -> sequencer completion, error flags unknown opcode
//   vga_*              : single-pixel write port, vga_plot is a one-cycle strobe
//   mem_*              : NN weight memory, mem_we one-cycle strobe, mem_rdata one cycle after mem_addr
//   instr_count        : completed-instruction counter
interface dp_executor_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int RESULT_WIDTH      = 16,
  parameter int X_COORD_WIDTH     = 8,
  parameter int Y_COORD_WIDTH     = 7,
  parameter int COLOUR_WIDTH      = 3,
  parameter int MEM_ADDR_WIDTH    = 6,
  parameter int MEM_DATA_WIDTH    = 16
);
  logic                         start;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         finished;
  logic [RESULT_WIDTH-1:0]      result;
  logic                         error;
  logic [X_COORD_WIDTH-1:0]     vga_x;
  logic [Y_COORD_WIDTH-1:0]     vga_y;
  logic [COLOUR_WIDTH-1:0]      vga_colour;
  logic                         vga_plot;
  logic [MEM_ADDR_WIDTH-1:0]    mem_addr;
  logic [MEM_DATA_WIDTH-1:0]    mem_wdata;
  logic                         mem_we;
  logic [MEM_DATA_WIDTH-1:0]    mem_rdata;
  logic [15:0]                  instr_count;

  // Sequencer/environment side: issues instructions and supplies read data.
  modport master (
    output start, instruction, mem_rdata,
    input  finished, result, error, vga_x, vga_y, vga_colour, vga_plot,
    input  mem_addr, mem_wdata, mem_we, instr_count
  );

  // Executor side.
  modport slave (
    input  start, instruction, mem_rdata,
    output finished, result, error, vga_x, vga_y, vga_colour, vga_plot,
    output mem_addr, mem_wdata, mem_we, instr_count
  );
endinterface

// File: rtl/dp_executor.sv
// Instruction executor: decodes one instruction at a time into a VGA pixel write or NN memory read/write.
// Latency: finished rises 1 cycle after accept (3 cycles for NNMEMREAD).
// Backpressure: a start rising edge while busy is dropped, not queued; finished high means ready.
//
// Ports:
//   i_clock : rising-edge clock
//   i_reset : synchronous active-high reset
//   io_bus  : dp_executor_if.slave (handshake, VGA port, NN memory port, instr_count)
module dp_executor #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int RESULT_WIDTH      = 16,
  parameter int X_COORD_WIDTH     = 8,
  parameter int Y_COORD_WIDTH     = 7,
  parameter int COLOUR_WIDTH      = 3,
  parameter int MEM_ADDR_WIDTH    = 6,
  parameter int MEM_DATA_WIDTH    = 16
) (
  input logic            i_clock,
  input logic            i_reset,
  dp_executor_if.slave   io_bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RD_CAP  = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_DRAW = 4'd1;
  localparam logic [3:0] OP_RD   = 4'd2;
  localparam logic [3:0] OP_WR   = 4'd3;

  // Highest instruction bit any opcode uses is 25 (write data); nothing above is kept.
  localparam int LATCH_W = 26;

  logic [1:0]                r_state;
  logic                      r_start_q;
  logic [LATCH_W-1:0]        r_instr;
  logic                      r_finished;
  logic [RESULT_WIDTH-1:0]   r_result;
  logic                      r_error;
  logic [X_COORD_WIDTH-1:0]  r_vga_x;
  logic [Y_COORD_WIDTH-1:0]  r_vga_y;
  logic [COLOUR_WIDTH-1:0]   r_vga_colour;
  logic                      r_vga_plot;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
  logic [MEM_DATA_WIDTH-1:0] r_mem_wdata;
  logic                      r_mem_we;
  logic [15:0]               r_instr_count;

  logic       w_accept;
  logic [3:0] w_opcode;

  // Only a rising edge of start while idle is an accept; a held-high start never re-triggers.
  assign w_accept = io_bus.start & ~r_start_q & (r_state == S_IDLE);
  assign w_opcode = r_instr[3:0];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_start_q     <= 1'b0;
      r_instr       <= '0;
      r_finished    <= 1'b1;
      r_result      <= '0;
      r_error       <= 1'b0;
      r_vga_x       <= '0;
      r_vga_y       <= '0;
      r_vga_colour  <= '0;
      r_vga_plot    <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_we      <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_start_q  <= io_bus.start;
      // Strobes default low so each is high for exactly the one cycle it is set.
      r_vga_plot <= 1'b0;
      r_mem_we   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_instr    <= io_bus.instruction[LATCH_W-1:0];
            r_finished <= 1'b0;
            r_error    <= 1'b0;
            r_state    <= S_EXEC;
          end
        end

        S_EXEC: begin
          r_state <= S_IDLE;
          case (w_opcode)
            OP_DRAW: begin
              r_vga_x       <= r_instr[4 +: X_COORD_WIDTH];
              r_vga_y       <= r_instr[12 +: Y_COORD_WIDTH];
              r_vga_colour  <= r_instr[19 +: COLOUR_WIDTH];
              r_vga_plot    <= r_instr[22];
              r_result      <= '0;
              r_finished    <= 1'b1;
              r_instr_count <= r_instr_count + 16'd1;
            end
            OP_WR: begin
              r_mem_addr    <= r_instr[4 +: MEM_ADDR_WIDTH];
              r_mem_wdata   <= r_instr[10 +: MEM_DATA_WIDTH];
              r_mem_we      <= 1'b1;
              r_result      <= '0;
              r_finished    <= 1'b1;
              r_instr_count <= r_instr_count + 16'd1;
            end
            OP_RD: begin
              r_mem_addr <= r_instr[4 +: MEM_ADDR_WIDTH];
              r_state    <= S_RD_WAIT;
            end
            OP_NOP: begin
              r_result      <= '0;
              r_finished    <= 1'b1;
              r_instr_count <= r_instr_count + 16'd1;
            end
            default: begin
              r_result      <= '0;
              r_error       <= 1'b1;
              r_finished    <= 1'b1;
              r_instr_count <= r_instr_count + 16'd1;
            end
          endcase
        end

        // Memory registers the address on this edge; data appears for the next one.
        S_RD_WAIT: r_state <= S_RD_CAP;

        S_RD_CAP: begin
          r_result      <= RESULT_WIDTH'(io_bus.mem_rdata);
          r_finished    <= 1'b1;
          r_instr_count <= r_instr_count + 16'd1;
          r_state       <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.finished    = r_finished;
  assign io_bus.result      = r_result;
  assign io_bus.error       = r_error;
  assign io_bus.vga_x       = r_vga_x;
  assign io_bus.vga_y       = r_vga_y;
  assign io_bus.vga_colour  = r_vga_colour;
  assign io_bus.vga_plot    = r_vga_plot;
  assign io_bus.mem_addr    = r_mem_addr;
  assign io_bus.mem_wdata   = r_mem_wdata;
  assign io_bus.mem_we      = r_mem_we;
  assign io_bus.instr_count = r_instr_count;
endmodule

// File: tb/tb_dp_executor.sv
// Self-checking bench for dp_executor: directed scenarios plus randomized instructions
// checked against an instruction-level reference model (field extraction + shadow memory).
module tb_dp_executor;
  logic clk;
  logic rst;
  logic mem_clr;

  dp_executor_if bus ();

  dp_executor dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External NN weight memory: synchronous read, one cycle latency.
  logic [15:0] mem_arr [64];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= 16'h0;
    end else begin
      if (bus.mem_we === 1'b1) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
  end

  // Strobe monitors: each sampled high cycle counts once.
  int plot_cnt = 0;
  int we_cnt   = 0;
  always @(posedge clk) begin
    if (bus.vga_plot === 1'b1) plot_cnt++;
    if (bus.mem_we === 1'b1) we_cnt++;
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_mem [64];
  logic [15:0] exp_count;

  function automatic logic [31:0] enc_draw(input logic [7:0] x, input logic [6:0] y,
                                           input logic [2:0] c, input logic p, input logic [8:0] junk);
    return {junk, p, c, y, x, 4'd1};
  endfunction
  function automatic logic [31:0] enc_wr(input logic [5:0] a, input logic [15:0] d, input logic [5:0] junk);
    return {junk, d, a, 4'd3};
  endfunction
  function automatic logic [31:0] enc_rd(input logic [5:0] a, input logic [21:0] junk);
    return {junk, a, 4'd2};
  endfunction

  task automatic hold();
    @(posedge clk); #1;
  endtask
  task automatic step();
    @(posedge clk); #1; bus.start = 1'b0;
  endtask
  // Raises start after one edge with start low; returns just after the accept edge A.
  task automatic send(input logic [31:0] ins);
    hold();
    bus.start = 1'b1;
    bus.instruction = ins;
    hold();
  endtask
  // Steps until finished is high; returns the number of edges after A (10 = timed out).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.finished !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.instruction = '0;
    repeat (2) hold();
    rst = 1'b0;
    mem_clr = 1'b0;
    hold();
    exp_count = 16'd0;
    checks++; if (bus.finished !== 1'b1) begin errors++; $display("FAIL reset_finished: got %b want 1", bus.finished); end
    checks++; if (bus.vga_plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %b want 0", bus.vga_plot); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
    checks++; if (bus.instr_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.instr_count); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus.error); end
  endtask

  task automatic test_draw_corner();
    int cyc;
    int p0;
    p0 = plot_cnt;
    send(enc_draw(8'd159, 7'd119, 3'b001, 1'b1, 9'h0));
    checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL draw_fin_at_A: got %b want 0", bus.finished); end
    wait_done(cyc);
    exp_count++;
    checks++; if (cyc != 1) begin errors++; $display("FAIL draw_latency: got %0d want 1", cyc); end
    checks++; if (bus.vga_plot !== 1'b1) begin errors++; $display("FAIL draw_plot_hi: got %b want 1", bus.vga_plot); end
    step();
    checks++; if (bus.vga_plot !== 1'b0) begin errors++; $display("FAIL draw_plot_lo: got %b want 0", bus.vga_plot); end
    checks++; if (plot_cnt != p0 + 1) begin errors++; $display("FAIL draw_pulses: got %0d want %0d", plot_cnt - p0, 1); end
    checks++; if (bus.vga_x !== 8'd159 || bus.vga_y !== 7'd119 || bus.vga_colour !== 3'd1) begin
      errors++; $display("FAIL draw_xyc: got %0d,%0d,%0d want 159,119,1", bus.vga_x, bus.vga_y, bus.vga_colour); end
    checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL draw_count: got %0d want %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_write_read();
    int cyc;
    int w0;
    w0 = we_cnt;
    send(enc_wr(6'd5, 16'hBEEF, 6'h2A));
    wait_done(cyc);
    step();
    exp_mem[5] = 16'hBEEF; exp_count++;
    checks++; if (cyc != 1) begin errors++; $display("FAIL wr_latency: got %0d want 1", cyc); end
    checks++; if (we_cnt != w0 + 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", we_cnt - w0); end
    checks++; if (bus.mem_addr !== 6'd5 || bus.mem_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL wr_port: got %0d/%h want 5/beef", bus.mem_addr, bus.mem_wdata); end
    send(enc_rd(6'd5, 22'h3FFFFF));
    wait_done(cyc);
    exp_count++;
    checks++; if (cyc != 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", cyc); end
    checks++; if (bus.result !== exp_mem[5]) begin errors++; $display("FAIL rd_result: got %h want %h", bus.result, exp_mem[5]); end
    checks++; if (we_cnt != w0 + 1) begin errors++; $display("FAIL rd_no_we: got %0d want 1", we_cnt - w0); end
    checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL rd_count: got %0d want %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_unknown_opcode();
    int cyc;
    send({28'hABCDEF1, 4'hF});
    wait_done(cyc);
    exp_count++;
    checks++; if (cyc != 1) begin errors++; $display("FAIL unk_latency: got %0d want 1", cyc); end
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL unk_error: got %b want 1", bus.error); end
    checks++; if (bus.result !== 16'h0) begin errors++; $display("FAIL unk_result: got %h want 0", bus.result); end
    send(32'h0);
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL nop_clears_error: got %b want 0", bus.error); end
    wait_done(cyc);
    exp_count++;
    checks++; if (cyc != 1 || bus.error !== 1'b0) begin errors++; $display("FAIL nop_done: got lat %0d err %b want 1/0", cyc, bus.error); end
    checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL unk_count: got %0d want %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_start_held();
    int p0;
    p0 = plot_cnt;
    send(enc_draw(8'd42, 7'd17, 3'd6, 1'b1, 9'h1FF));
    repeat (10) hold();
    exp_count++;
    checks++; if (plot_cnt != p0 + 1) begin errors++; $display("FAIL held_pulses: got %0d want 1", plot_cnt - p0); end
    checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL held_count: got %0d want %0d", bus.instr_count, exp_count); end
    step(); hold();
    checks++; if (bus.finished !== 1'b1 || bus.instr_count !== exp_count) begin
      errors++; $display("FAIL held_release: got fin %b cnt %0d want 1/%0d", bus.finished, bus.instr_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = plot_cnt;
    send(enc_draw(8'd10, 7'd20, 3'd3, 1'b1, 9'h0));
    bus.start = 1'b0;
    hold();
    checks++; if (bus.finished !== 1'b1 || bus.vga_x !== 8'd10) begin
      errors++; $display("FAIL b2b_first: got fin %b x %0d want 1/10", bus.finished, bus.vga_x); end
    bus.start = 1'b1;
    bus.instruction = enc_draw(8'd30, 7'd40, 3'd5, 1'b1, 9'h0);
    hold();
    checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL b2b_accept: got %b want 0", bus.finished); end
    step();
    checks++; if (bus.finished !== 1'b1 || bus.vga_x !== 8'd30) begin
      errors++; $display("FAIL b2b_second: got fin %b x %0d want 1/30", bus.finished, bus.vga_x); end
    step();
    exp_count += 16'd2;
    checks++; if (plot_cnt != p0 + 2 || bus.instr_count !== exp_count) begin
      errors++; $display("FAIL b2b_totals: got %0d pulses cnt %0d want 2/%0d", plot_cnt - p0, bus.instr_count, exp_count); end
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    int w0;
    send(enc_rd(6'd5, 22'h0));
    wait_done(cyc);
    send(enc_rd(6'd5, 22'h0));
    step();                       // now in the read-wait cycle
    w0 = we_cnt;
    rst = 1'b1;
    hold();
    rst = 1'b0;
    exp_count = 16'd0;
    checks++; if (bus.finished !== 1'b1) begin errors++; $display("FAIL rstrd_finished: got %b want 1", bus.finished); end
    checks++; if (bus.result !== 16'h0) begin errors++; $display("FAIL rstrd_result: got %h want 0", bus.result); end
    checks++; if (bus.instr_count !== 16'h0 || bus.vga_x !== 8'h0) begin
      errors++; $display("FAIL rstrd_regs: got cnt %0d x %0d want 0/0", bus.instr_count, bus.vga_x); end
    hold(); hold();
    checks++; if (we_cnt != w0 || bus.result !== 16'h0) begin
      errors++; $display("FAIL rstrd_quiet: got we %0d res %h want 0/0", we_cnt - w0, bus.result); end
    send(enc_rd(6'd5, 22'h15555));
    wait_done(cyc);
    exp_count++;
    checks++; if (cyc != 3 || bus.result !== exp_mem[5]) begin
      errors++; $display("FAIL rstrd_fresh: got lat %0d res %h want 3/%h", cyc, bus.result, exp_mem[5]); end
    checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL rstrd_count: got %0d want %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ins;
      logic [3:0]  op;
      int kind, cyc, p0, w0, exp_lat, exp_plot, exp_we;
      logic [15:0] exp_res;
      logic        exp_err;
      kind = $urandom_range(0, 4);
      ins  = $urandom;
      op   = (kind == 4) ? 4'($urandom_range(4, 15)) : 4'(kind);
      ins  = (ins & 32'hFFFF_FFF0) | 32'(op);
      // Reference: decode fields arithmetically from the instruction word.
      exp_lat = (op == 4'd2) ? 3 : 1;
      exp_res = 16'h0; exp_err = (op > 4'd3); exp_plot = 0; exp_we = 0;
      if (op == 4'd1) exp_plot = (ins >> 22) & 1;
      if (op == 4'd3) exp_we = 1;
      if (op == 4'd2) exp_res = exp_mem[(ins >> 4) % 64];
      p0 = plot_cnt; w0 = we_cnt;
      send(ins);
      checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy: got %b want 0", n, bus.finished); end
      wait_done(cyc);
      step();
      exp_count++;
      if (op == 4'd3) exp_mem[(ins >> 4) % 64] = 16'((ins >> 10) % 65536);
      checks++; if (cyc != exp_lat) begin errors++; $display("FAIL rnd%0d_latency: op %0d got %0d want %0d", n, op, cyc, exp_lat); end
      checks++; if (bus.result !== exp_res || bus.error !== exp_err) begin
        errors++; $display("FAIL rnd%0d_result: op %0d got %h/%b want %h/%b", n, op, bus.result, bus.error, exp_res, exp_err); end
      checks++; if (plot_cnt - p0 != exp_plot || we_cnt - w0 != exp_we) begin
        errors++; $display("FAIL rnd%0d_strobes: op %0d got %0d/%0d want %0d/%0d", n, op, plot_cnt - p0, we_cnt - w0, exp_plot, exp_we); end
      checks++; if (bus.instr_count !== exp_count) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", n, bus.instr_count, exp_count); end
      if (op == 4'd1) begin
        checks++;
        if (32'(bus.vga_x) != ((ins >> 4) % 256) || 32'(bus.vga_y) != ((ins >> 12) % 128) || 32'(bus.vga_colour) != ((ins >> 19) % 8)) begin
          errors++; $display("FAIL rnd%0d_draw: got %0d,%0d,%0d want %0d,%0d,%0d", n, bus.vga_x, bus.vga_y, bus.vga_colour,
                             (ins >> 4) % 256, (ins >> 12) % 128, (ins >> 19) % 8);
        end
      end
      if (op == 4'd2 || op == 4'd3) begin
        checks++; if (32'(bus.mem_addr) != ((ins >> 4) % 64)) begin
          errors++; $display("FAIL rnd%0d_addr: got %0d want %0d", n, bus.mem_addr, (ins >> 4) % 64); end
      end
    end
  endtask

  initial begin
    mem_clr = 1'b1;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.instruction = '0;
    exp_count = 16'd0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 16'h0;
    test_reset();
    test_draw_corner();
    test_write_read();
    test_unknown_opcode();
    test_start_held();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end
endmodule
